// File: rtl/ps2_pkg.sv
// Shared PS/2 byte constants, prefix FSM encodings and the queued key-event layout.
package ps2_pkg;

  localparam logic [7:0] PS2_EXT    = 8'hE0;
  localparam logic [7:0] PS2_BRK    = 8'hF0;
  localparam logic [7:0] PS2_BAT_OK = 8'hAA;
  localparam logic [7:0] PS2_ACK    = 8'hFA;
  localparam logic [7:0] PS2_ECHO   = 8'hEE;
  localparam logic [7:0] PS2_RESEND = 8'hFE;
  localparam logic [7:0] PS2_ERR0   = 8'h00;
  localparam logic [7:0] PS2_ERR1   = 8'hFF;

  localparam int unsigned EV_W  = 10;
  localparam int unsigned CNT_W = 5;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_EXT     = 2'd1,
    ST_BRK     = 2'd2,
    ST_EXT_BRK = 2'd3
  } ps2_state_e;

  typedef struct packed {
    logic       ext;
    logic       brk;
    logic [7:0] code;
  } ps2_event_t;

  // Keyboard status/handshake bytes that never represent a key when seen unprefixed.
  function automatic logic is_status(input logic [7:0] b);
    return (b == PS2_ERR0) || (b == PS2_BAT_OK) || (b == PS2_ECHO) ||
           (b == PS2_ACK)  || (b == PS2_RESEND) || (b == PS2_ERR1);
  endfunction

endpackage

// File: rtl/ps2_event_fifo.sv
// Show-ahead FIFO with a registered head word that holds its last value when empty.
module ps2_event_fifo
  import ps2_pkg::*;
#(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_o,
  output logic             valid_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CNT_W-1:0] count_o
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_q, wr_d, rd_q, rd_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [WIDTH-1:0] head_q, head_d;
  logic             valid_q, full_q;
  logic             do_push, do_pop;

  always_comb begin
    do_pop  = pop_i && (count_q != '0);
    do_push = push_i && ((count_q != CNT_W'(DEPTH)) || do_pop);
    wr_d    = wr_q + AW'(do_push);
    rd_d    = rd_q + AW'(do_pop);
    count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    head_d  = head_q;
    // The pushed word becomes head only when nothing older survives this cycle.
    if (count_d != '0) begin
      if ((count_q - CNT_W'(do_pop)) == '0) head_d = push_data_i;
      else                                  head_d = mem_q[rd_d];
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= push_data_i;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
      head_q  <= '0;
      valid_q <= 1'b0;
      full_q  <= 1'b0;
    end else begin
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      count_q <= count_d;
      head_q  <= head_d;
      valid_q <= (count_d != '0);
      full_q  <= (count_d == CNT_W'(DEPTH));
    end
  end

  assign head_o  = head_q;
  assign valid_o = valid_q;
  assign full_o  = full_q;
  assign empty_o = !valid_q;
  assign count_o = count_q;

endmodule

// File: rtl/ps2_key_event_ctrl.sv
// PS/2 prefix sequencer: folds E0/F0 prefixes into key events and queues them for a consumer.
module ps2_key_event_ctrl
  import ps2_pkg::*;
#(
  parameter int unsigned DEPTH       = 8,
  parameter int unsigned TIMEOUT_CYC = 50000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [7:0]       rx_data,
  input  logic             rx_ready,
  output logic             ev_valid,
  output logic [7:0]       ev_code,
  output logic             ev_break,
  output logic             ev_extended,
  input  logic             ev_pop,
  output logic [CNT_W-1:0] count,
  output logic             busy,
  output logic             overflow,
  input  logic             ovf_clr
);

  localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);

  ps2_state_e  state_q, state_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic        busy_q;
  logic        ovf_q, ovf_d;
  logic        push;
  ps2_event_t  ev_d;
  ps2_event_t  head;
  logic [EV_W-1:0] head_raw;
  logic        fifo_full, fifo_empty, fifo_valid;

  // Prefix FSM; a byte arriving on the expiry cycle is processed in the current state.
  always_comb begin
    state_d = state_q;
    tmo_d   = '0;
    push    = 1'b0;
    ev_d    = '0;
    if (rx_ready) begin
      ev_d.code = rx_data;
      unique case (state_q)
        ST_IDLE: begin
          if (rx_data == PS2_EXT)      state_d = ST_EXT;
          else if (rx_data == PS2_BRK) state_d = ST_BRK;
          else if (!is_status(rx_data)) push = 1'b1;
        end
        ST_EXT: begin
          if (rx_data == PS2_BRK) state_d = ST_EXT_BRK;
          else if (rx_data != PS2_EXT) begin
            ev_d.ext = 1'b1;
            push     = 1'b1;
            state_d  = ST_IDLE;
          end
        end
        ST_BRK: begin
          if (rx_data == PS2_EXT) state_d = ST_EXT_BRK;
          else if (rx_data != PS2_BRK) begin
            ev_d.brk = 1'b1;
            push     = 1'b1;
            state_d  = ST_IDLE;
          end
        end
        ST_EXT_BRK: begin
          if ((rx_data != PS2_EXT) && (rx_data != PS2_BRK)) begin
            ev_d.ext = 1'b1;
            ev_d.brk = 1'b1;
            push     = 1'b1;
            state_d  = ST_IDLE;
          end
        end
      endcase
    end else if (state_q != ST_IDLE) begin
      if (tmo_q == TW'(TIMEOUT_CYC - 1)) state_d = ST_IDLE;
      else                               tmo_d   = tmo_q + TW'(1);
    end
  end

  // A drop (full, no accepted pop) beats a same-cycle clear.
  always_comb begin
    ovf_d = ovf_q;
    if (push && fifo_full && !(ev_pop && fifo_valid)) ovf_d = 1'b1;
    else if (ovf_clr)                                 ovf_d = 1'b0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      tmo_q   <= '0;
      busy_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      tmo_q   <= tmo_d;
      busy_q  <= (state_d != ST_IDLE);
      ovf_q   <= ovf_d;
    end
  end

  ps2_event_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (EV_W)
  ) u_fifo (
    .clk         (clk),
    .reset       (reset),
    .push_i      (push),
    .push_data_i (EV_W'(ev_d)),
    .pop_i       (ev_pop),
    .head_o      (head_raw),
    .valid_o     (fifo_valid),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .count_o     (count)
  );

  assign head        = ps2_event_t'(head_raw);
  assign ev_valid    = fifo_valid && !fifo_empty;
  assign ev_code     = head.code;
  assign ev_break    = head.brk;
  assign ev_extended = head.ext;
  assign busy        = busy_q;
  assign overflow    = ovf_q;

endmodule

// File: tb/tb_ps2_key_event_ctrl.sv
// Directed scoreboard bench for ps2_key_event_ctrl: expected events queued at stimulus, checked at pop.
module tb_ps2_key_event_ctrl;

  localparam int TMO = 20;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       rx_ready = 1'b0;
  logic       ev_valid, ev_break, ev_extended;
  logic [7:0] ev_code;
  logic       ev_pop = 1'b0;
  logic [4:0] count;
  logic       busy, overflow;
  logic       ovf_clr = 1'b0;
  logic       pop_en = 1'b0;

  int n_vec = 0;
  int n_err = 0;
  int exp_q[$];

  ps2_key_event_ctrl #(.DEPTH(8), .TIMEOUT_CYC(TMO)) dut (
    .clk         (clk),
    .reset       (reset),
    .rx_data     (rx_data),
    .rx_ready    (rx_ready),
    .ev_valid    (ev_valid),
    .ev_code     (ev_code),
    .ev_break    (ev_break),
    .ev_extended (ev_extended),
    .ev_pop      (ev_pop),
    .count       (count),
    .busy        (busy),
    .overflow    (overflow),
    .ovf_clr     (ovf_clr)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: on the falling edge, compare the presented head with the scoreboard and accept it.
  always @(negedge clk) begin
    if (ev_valid && pop_en) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_event", {22'd0, ev_extended, ev_break, ev_code}, -1);
      end else begin
        chk("event", {22'd0, ev_extended, ev_break, ev_code}, exp_q.pop_front());
      end
      ev_pop = 1'b1;
    end else begin
      ev_pop = 1'b0;
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    rx_data  = b;
    rx_ready = 1'b1;
    cyc();
    rx_ready = 1'b0;
  endtask

  function automatic int ev(input bit ext, input bit brk, input logic [7:0] code);
    return {22'd0, ext, brk, code};
  endfunction

  task automatic drain();
    int k;
    pop_en = 1'b1;
    for (k = 0; k < 40; k++) begin
      cyc();
      if (exp_q.size() == 0 && !ev_valid) break;
    end
    chk("drain_done", int'(k < 40), 1);
    pop_en = 1'b0;
  endtask

  initial begin
    cyc(); cyc();
    chk("rst_count", count, 0);
    chk("rst_valid", ev_valid, 0);
    chk("rst_code", ev_code, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ovf", overflow, 0);
    reset = 1'b1;
    cyc();

    // Make then release, held in the FIFO until drained
    send(8'h1C); exp_q.push_back(ev(0, 0, 8'h1C));
    chk("make_latency_valid", ev_valid, 1);
    send(8'hF0);
    send(8'h1C); exp_q.push_back(ev(0, 1, 8'h1C));
    chk("mr_count", count, 2);
    chk("mr_head_code", ev_code, 8'h1C);
    chk("mr_head_brk", ev_break, 0);
    drain();
    chk("mr_empty", ev_valid, 0);
    chk("mr_hold_code", ev_code, 8'h1C);
    chk("mr_hold_brk", ev_break, 1);

    // Extended release
    pop_en = 1'b1;
    send(8'hE0);
    chk("ext_busy1", busy, 1);
    send(8'hF0);
    chk("ext_busy2", busy, 1);
    send(8'h75); exp_q.push_back(ev(1, 1, 8'h75));
    chk("ext_busy_clear", busy, 0);
    drain();

    // Prefix abandoned after the timeout, then a plain make
    send(8'hE0);
    for (int i = 0; i < TMO - 1; i++) cyc();
    chk("tmo_busy_before", busy, 1);
    cyc();
    chk("tmo_busy_expired", busy, 0);
    send(8'h29); exp_q.push_back(ev(0, 0, 8'h29));
    drain();

    // Byte on the exact expiry cycle wins
    send(8'hE0);
    for (int i = 0; i < TMO - 1; i++) cyc();
    chk("tmo_edge_busy", busy, 1);
    send(8'h29); exp_q.push_back(ev(1, 0, 8'h29));
    chk("tmo_edge_busy_after", busy, 0);
    drain();

    // Status bytes filtered only when unprefixed
    send(8'hAA);
    send(8'hFA);
    cyc();
    chk("status_count", count, 0);
    chk("status_valid", ev_valid, 0);
    send(8'hF0);
    send(8'hAA); exp_q.push_back(ev(0, 1, 8'hAA));
    drain();

    // Overflow: ninth make code is dropped
    for (int i = 0; i < 9; i++) begin
      send(8'h10 + 8'(i));
      if (i < 8) exp_q.push_back(ev(0, 0, 8'h10 + 8'(i)));
    end
    cyc();
    chk("ovf_count", count, 8);
    chk("ovf_flag", overflow, 1);
    chk("ovf_head", ev_code, 8'h10);
    ovf_clr = 1'b1;
    cyc();
    ovf_clr = 1'b0;
    chk("ovf_cleared", overflow, 0);

    // Full with simultaneous push and pop
    pop_en   = 1'b1;
    rx_data  = 8'h3A;
    rx_ready = 1'b1;
    exp_q.push_back(ev(0, 0, 8'h3A));
    cyc();
    pop_en   = 1'b0;
    rx_ready = 1'b0;
    cyc();
    chk("fullpp_count", count, 8);
    chk("fullpp_ovf", overflow, 0);
    chk("fullpp_head", ev_code, 8'h11);

    // Dropping push wins over ovf_clr
    rx_data  = 8'h4B;
    rx_ready = 1'b1;
    ovf_clr  = 1'b1;
    cyc();
    rx_ready = 1'b0;
    ovf_clr  = 1'b0;
    chk("ovf_set_wins", overflow, 1);
    chk("ovf_drop_count", count, 8);
    drain();
    ovf_clr = 1'b1;
    cyc();
    ovf_clr = 1'b0;

    // Reset mid-sequence flushes FIFO and prefix state
    send(8'h11);
    send(8'hE0);
    reset = 1'b0;
    cyc();
    reset = 1'b1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_count", count, 0);
    chk("mid_rst_code", ev_code, 0);
    send(8'h1C); exp_q.push_back(ev(0, 0, 8'h1C));
    chk("mid_rst_one_event", count, 1);
    drain();

    chk("scoreboard_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ps2_key_event_ctrl.md
Name: ps2_key_event_ctrl

Overview:
- Sequencer between the PS/2 byte receiver and downstream logic (display, game, UART bridge).
- Consumes the receiver's byte plus one-cycle ready pulse and tracks the E0 (extended) and F0 (break) prefixes.
- Assembles each complete make/break sequence into a key event and queues it in a FIFO.
- Consumer drains the FIFO with a valid/pop handshake; also provides prefix timeout, status-code filtering and sticky overflow.

Parameters:
- DEPTH, 8, FIFO entries; power of two, 2..16.
- TIMEOUT_CYC, 50000, clk cycles a prefix state may wait for its next byte before being abandoned (1 ms at 50 MHz).

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous active-low reset
- rx_data  input  8  scan-code byte from receiver, valid when rx_ready=1
- rx_ready  input  1  one-cycle strobe, new byte on rx_data
- ev_valid  output  1  FIFO non-empty; head event presented
- ev_code  output  8  head event scan code (prefix stripped)
- ev_break  output  1  head event is key release
- ev_extended  output  1  head event carried E0 prefix
- ev_pop  input  1  consumer accepts head event (acts only when ev_valid=1)
- count  output  5  FIFO occupancy, 0..DEPTH
- busy  output  1  prefix pending (state != IDLE)
- overflow  output  1  sticky: an event was dropped because FIFO was full
- ovf_clr  input  1  clears overflow

Behaviour:
- Reset (reset=0, asynchronous) forces:
  - state=IDLE, FIFO empty, count=0, ev_valid=0, ev_code=0, ev_break=0, ev_extended=0, busy=0, overflow=0, timeout counter=0.
- Bytes are sampled only on clk edges where rx_ready=1. rx_ready held high longer is treated as one byte per cycle; the upstream guarantees single-cycle pulses.
- FSM states: IDLE, EXT (E0 seen), BRK (F0 seen), EXT_BRK (E0,F0 seen).
  - IDLE:
    - E0 -> EXT.
    - F0 -> BRK.
    - Status bytes 00, AA, EE, FA, FE, FF are discarded; stay IDLE.
    - Any other byte b -> push {break=0, ext=0, code=b}; stay IDLE.
  - EXT:
    - F0 -> EXT_BRK.
    - E0 -> stay EXT and restart timeout.
    - Other b -> push {0,1,b}; -> IDLE.
  - BRK:
    - F0 -> stay BRK and restart timeout.
    - E0 -> EXT_BRK (tolerate reordered prefix).
    - Other b -> push {1,0,b}; -> IDLE.
  - EXT_BRK:
    - E0 or F0 -> stay and restart timeout.
    - Other b -> push {1,1,b}; -> IDLE.
  - In non-IDLE states, status bytes are treated as ordinary codes (no filtering after a prefix).
- Timeout:
  - Counter clears on every accepted byte and in IDLE; increments each cycle while state != IDLE.
  - On reaching TIMEOUT_CYC-1 with no rx_ready that cycle: -> IDLE, no push, counter cleared.
  - rx_ready on the same cycle as expiry: the byte wins and is processed in the current state.
- busy = (state != IDLE), registered with state.
- Latency: push occurs on the clk edge that samples the final byte; if FIFO was empty, ev_valid=1 and head fields valid from the following cycle.
- FIFO (show-ahead):
  - ev_* are driven from the head entry and are stable while ev_valid=1 and no pop.
  - ev_* hold their last value when empty.
  - Pop with ev_valid=0 is ignored.
- Simultaneous push and pop:
  - Non-empty: both occur; count unchanged.
  - Empty: push only; pop ignored.
  - Full with pop: both occur; no overflow.
- Push when full without pop: event dropped, overflow set next edge, FIFO unchanged.
- overflow: set has priority over ovf_clr in the same cycle; otherwise ovf_clr clears it.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH; count is a separate 5-bit register.

Decomposition:
- Shared package ps2_pkg:
  - Byte constants PS2_EXT=8'hE0, PS2_BRK=8'hF0, PS2_BAT_OK=8'hAA, PS2_ACK=8'hFA, PS2_ECHO=8'hEE, PS2_RESEND=8'hFE, PS2_ERR0=8'h00, PS2_ERR1=8'hFF.
  - FSM state encodings (2-bit).
  - Event word layout {ext, brk, code[7:0]} = 10 bits.
- One sub-module, ps2_event_fifo: synchronous show-ahead FIFO, parameter DEPTH and WIDTH=10, same clk/reset, push/pop/full/empty/count ports.
- Prefix FSM and timeout counter stay in the top.

Test Plan:
- Make and release: bytes 1C, F0, 1C (no pop) -> count=2; head {brk0,ext0,1C}; after pop, head {brk1,ext0,1C}; after second pop, ev_valid=0.
- Extended release: bytes E0, F0, 75 -> busy=1 between bytes; one event {brk1,ext1,75}; busy=0 the cycle after 75.
- Timeout: byte E0, idle TIMEOUT_CYC cycles, then 29 -> busy drops at expiry; event {brk0,ext0,29}, not extended. With rx_ready on the exact expiry cycle: event {0,1,29}.
- Status filtering: AA, FA in IDLE -> no events, count=0. Sequence F0, AA -> event {1,0,AA}.
- Overflow: DEPTH+1 make codes with no pop -> count=8, overflow=1, head is first code. Same cycle push+pop while full -> count stays 8, no new overflow. ovf_clr together with a dropping push -> overflow stays 1.
- Reset mid-sequence: E0 then reset low for 1 cycle, then 1C -> state IDLE, FIFO flushed, single event {0,0,1C}.
